// File: rtl/dcache_ctrl_nb.sv
// Non-blocking write-through D$ controller: associative MSHR file keyed by Dmem tag.
// Optional secondary-miss merging is enabled by defining DCACHE_MSHR_MERGE_EN.
module dcache_ctrl_nb #(
  parameter int unsigned IDX_BITS = 5,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned NUM_MSHR = 4,
  parameter int unsigned ID_BITS  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          proc2Dcache_command,
  input  logic [63:0]         proc2Dcache_addr,
  input  logic [63:0]         proc2Dcache_data,
  input  logic [ID_BITS-1:0]  proc2Dcache_id,
  output logic                Dcache2proc_ready,
  output logic                Dcache2proc_valid,
  output logic [63:0]         Dcache2proc_data,
  output logic [ID_BITS-1:0]  Dcache2proc_id,
  input  logic [3:0]          Dmem2Dcache_response,
  input  logic [3:0]          Dmem2Dcache_tag,
  input  logic [63:0]         Dmem2Dcache_data,
  output logic [1:0]          Dcache2Dmem_command,
  output logic [63:0]         Dcache2Dmem_addr,
  output logic [63:0]         Dcache2Dmem_data,
  output logic [IDX_BITS-1:0] rd_idx,
  output logic [TAG_BITS-1:0] rd_tag,
  input  logic [63:0]         cachemem_data,
  input  logic                cachemem_valid,
  output logic                wr_en,
  output logic [IDX_BITS-1:0] wr_idx,
  output logic [TAG_BITS-1:0] wr_tag,
  output logic [63:0]         wr_data
);
  localparam int unsigned LINE_BITS = 61;
  localparam int unsigned MSHR_W    = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam logic [1:0]  BUS_NONE  = 2'd0;
  localparam logic [1:0]  BUS_LOAD  = 2'd1;
  localparam logic [1:0]  BUS_STORE = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [3:0]           mem_tag;
    logic [LINE_BITS-1:0] line;
    logic [ID_BITS-1:0]   id;
    logic                 stale;
  } mshr_t;

  mshr_t mshr_q [NUM_MSHR];
  mshr_t mshr_d [NUM_MSHR];

  logic [LINE_BITS-1:0] req_line;
  logic [3:0]           fill_tag;
  logic [63:0]          fill_data;
  logic                 draining;
  logic                 fill_hit;
  logic                 fill_more;
  logic [MSHR_W-1:0]    fill_idx;
  logic                 free_hit;
  logic [MSHR_W-1:0]    free_idx;
  logic                 accept;
  logic                 resp_valid_d;
  logic [63:0]          resp_data_d;
  logic [ID_BITS-1:0]   resp_id_d;
  logic                 unused_bits;

  assign req_line = proc2Dcache_addr[63:3];

`ifdef DCACHE_MSHR_MERGE_EN
  typedef enum logic {S_IDLE, S_DRAIN} state_t;
  state_t      state_q, state_d;
  logic [3:0]  drain_tag_q, drain_tag_d;
  logic [63:0] drain_data_q, drain_data_d;
  logic        sec_hit;
  logic [3:0]  sec_tag;

  // While draining, the captured fill keeps servicing entries sharing its tag.
  assign draining    = (state_q == S_DRAIN);
  assign fill_tag    = draining ? drain_tag_q : Dmem2Dcache_tag;
  assign fill_data   = draining ? drain_data_q : Dmem2Dcache_data;
  assign unused_bits = ^proc2Dcache_addr[2:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      drain_tag_q  <= '0;
      drain_data_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_tag_q  <= drain_tag_d;
      drain_data_q <= drain_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_tag_d  = drain_tag_q;
    drain_data_d = drain_data_q;
    if (fill_hit && fill_more) begin
      state_d      = S_DRAIN;
      drain_tag_d  = fill_tag;
      drain_data_d = fill_data;
    end else begin
      state_d = S_IDLE;
    end
  end

  // Secondary miss: line already in flight on a non-stale entry.
  always_comb begin
    sec_hit = 1'b0;
    sec_tag = '0;
    for (int i = 0; i < int'(NUM_MSHR); i++) begin
      if (mshr_q[i].valid && !mshr_q[i].stale && mshr_q[i].line == req_line) begin
        sec_hit = 1'b1;
        sec_tag = mshr_q[i].mem_tag;
      end
    end
  end
`else
  assign draining    = 1'b0;
  assign fill_tag    = Dmem2Dcache_tag;
  assign fill_data   = Dmem2Dcache_data;
  assign unused_bits = ^{proc2Dcache_addr[2:0], fill_more};
`endif

  // Lowest-index MSHR matching the fill tag; fill_more flags further matches.
  always_comb begin
    fill_hit  = 1'b0;
    fill_more = 1'b0;
    fill_idx  = '0;
    for (int i = int'(NUM_MSHR) - 1; i >= 0; i--) begin
      if (mshr_q[i].valid && fill_tag != 4'd0 && mshr_q[i].mem_tag == fill_tag) begin
        fill_more = fill_more | fill_hit;
        fill_hit  = 1'b1;
        fill_idx  = MSHR_W'(i);
      end
    end
  end

  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = int'(NUM_MSHR) - 1; i >= 0; i--) begin
      if (!mshr_q[i].valid) begin
        free_hit = 1'b1;
        free_idx = MSHR_W'(i);
      end
    end
  end

  // Request arbitration: fill first, then the LSQ request.
  always_comb begin
    for (int i = 0; i < int'(NUM_MSHR); i++) mshr_d[i] = mshr_q[i];
    accept              = 1'b0;
    Dcache2proc_ready   = 1'b0;
    Dcache2Dmem_command = BUS_NONE;
    Dcache2Dmem_addr    = '0;
    Dcache2Dmem_data    = '0;
    rd_idx              = '0;
    rd_tag              = '0;
    wr_en               = 1'b0;
    wr_idx              = '0;
    wr_tag              = '0;
    wr_data             = '0;
    resp_valid_d        = 1'b0;
    resp_data_d         = Dcache2proc_data;
    resp_id_d           = Dcache2proc_id;
    if (fill_hit) begin
      wr_en                   = !mshr_q[fill_idx].stale && !draining;
      wr_idx                  = mshr_q[fill_idx].line[IDX_BITS-1:0];
      wr_tag                  = mshr_q[fill_idx].line[IDX_BITS +: TAG_BITS];
      wr_data                 = fill_data;
      resp_valid_d            = 1'b1;
      resp_data_d             = fill_data;
      resp_id_d               = mshr_q[fill_idx].id;
      mshr_d[fill_idx].valid  = 1'b0;
    end else if (!draining) begin
      case (proc2Dcache_command)
        BUS_LOAD: begin
          rd_idx = req_line[IDX_BITS-1:0];
          rd_tag = req_line[IDX_BITS +: TAG_BITS];
          if (cachemem_valid) begin
            accept       = 1'b1;
            resp_valid_d = 1'b1;
            resp_data_d  = cachemem_data;
            resp_id_d    = proc2Dcache_id;
`ifdef DCACHE_MSHR_MERGE_EN
          end else if (sec_hit) begin
            accept = free_hit;
            if (free_hit) begin
              mshr_d[free_idx] = '{valid: 1'b1, mem_tag: sec_tag, line: req_line,
                                   id: proc2Dcache_id, stale: 1'b0};
            end
`endif
          end else if (free_hit) begin
            Dcache2Dmem_command = BUS_LOAD;
            Dcache2Dmem_addr    = {req_line, 3'b000};
            accept              = (Dmem2Dcache_response != 4'd0);
            if (accept) begin
              mshr_d[free_idx] = '{valid: 1'b1, mem_tag: Dmem2Dcache_response, line: req_line,
                                   id: proc2Dcache_id, stale: 1'b0};
            end
          end
        end
        BUS_STORE: begin
          Dcache2Dmem_command = BUS_STORE;
          Dcache2Dmem_addr    = {req_line, 3'b000};
          Dcache2Dmem_data    = proc2Dcache_data;
          accept              = (Dmem2Dcache_response != 4'd0);
          if (accept) begin
            wr_en   = 1'b1;
            wr_idx  = req_line[IDX_BITS-1:0];
            wr_tag  = req_line[IDX_BITS +: TAG_BITS];
            wr_data = proc2Dcache_data;
            // Outstanding fills for this line would overwrite newer store data.
            for (int i = 0; i < int'(NUM_MSHR); i++) begin
              if (mshr_q[i].valid && mshr_q[i].line == req_line) mshr_d[i].stale = 1'b1;
            end
          end
        end
        default: ;
      endcase
      Dcache2proc_ready = accept;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_MSHR); i++) mshr_q[i] <= '0;
      Dcache2proc_valid <= 1'b0;
      Dcache2proc_data  <= '0;
      Dcache2proc_id    <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_MSHR); i++) mshr_q[i] <= mshr_d[i];
      Dcache2proc_valid <= resp_valid_d;
      Dcache2proc_data  <= resp_data_d;
      Dcache2proc_id    <= resp_id_d;
    end
  end

endmodule

// File: doc/dcache_ctrl_nb.md
Name: dcache_ctrl_nb

Overview:
Non-blocking, write-through data cache controller between the LSQ and Dmem. It is a parametrised successor to the single-miss-register controller. It tracks up to NUM_MSHR outstanding load misses in an associative MSHR file keyed by Dmem tag, and returns each load's LSQ id with its data. It registers all proc responses, back-pressures the LSQ, and keeps stale fills out of the cache.

Parameters:
IDX_BITS, 5, cache index width (line = 8 bytes; idx = addr[IDX_BITS+2:3])
TAG_BITS, 8, cache tag width (tag = addr[IDX_BITS+TAG_BITS+2:IDX_BITS+3])
NUM_MSHR, 4, outstanding-miss entries, 1..15
ID_BITS, 4, LSQ request id width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
proc2Dcache_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE
proc2Dcache_addr  in  64  byte address
proc2Dcache_data  in  64  store data
proc2Dcache_id  in  ID_BITS  LSQ id of request
Dcache2proc_ready  out  1  request accepted this cycle (combinational)
Dcache2proc_valid  out  1  load response valid (registered)
Dcache2proc_data  out  64  load data (registered)
Dcache2proc_id  out  ID_BITS  id of responding load (registered)
Dmem2Dcache_response  in  4  Dmem accept tag, 0 = not accepted
Dmem2Dcache_tag  in  4  returning fill tag, 0 = none
Dmem2Dcache_data  in  64  fill data
Dcache2Dmem_command  out  2  bus command
Dcache2Dmem_addr  out  64  {addr[63:3],3'b0}
Dcache2Dmem_data  out  64  store data
rd_idx  out  IDX_BITS  cachemem read index
rd_tag  out  TAG_BITS  cachemem read tag
cachemem_data  in  64  read data (combinational)
cachemem_valid  in  1  read hit
wr_en  out  1  cachemem write
wr_idx  out  IDX_BITS  write index
wr_tag  out  TAG_BITS  write tag
wr_data  out  64  write data

Behaviour:
- Reset (reset=0, async): all MSHRs free; Dcache2proc_valid=0, data=0, id=0. Combinational outputs default to 0 / BUS_NONE.
- MSHR entry fields: valid, mem_tag[3:0], line addr[63:3], id, stale.
- Priority 1, fill (Dmem2Dcache_tag!=0 matching a valid MSHR):
  - wr_en=1, wr_idx/wr_tag from the MSHR address, unless stale=1.
  - Next cycle: Dcache2proc_valid=1 with fill data and the MSHR id.
  - The entry frees at the clock edge.
  - Dcache2proc_ready=0 and Dcache2Dmem_command=BUS_NONE this cycle.
  - A tag matching no MSHR is ignored.
- Priority 2, load (no fill):
  - rd_idx/rd_tag driven from the address.
  - Hit: ready=1; next cycle valid=1 with cachemem_data and proc id. Latency 1.
  - Miss with a free MSHR: command=BUS_LOAD. ready = (Dmem2Dcache_response!=0). On accept, the lowest-index free MSHR is written with mem_tag=response, stale=0.
  - Miss with MSHRs full: command=BUS_NONE, ready=0.
- Priority 2, store:
  - command=BUS_STORE; ready = (response!=0).
  - On accept: wr_en=1 with store data.
  - Every valid MSHR whose line equals the store line sets stale=1. This has no effect on a same-cycle freeing entry, because fills block stores.
- Simultaneous fill and request: the fill wins; the request sees ready=0 and must be held by the LSQ.
- A request is not accepted unless ready=1 in that cycle; unaccepted requests cause no state change.
- Dcache2proc_valid is a one-cycle pulse per response; at most one response per cycle.
- Dmem guarantees tags are unique while outstanding; the block does not check this.

Optional Feature:
DCACHE_MSHR_MERGE_EN
- Defined: a load miss whose line matches a valid, non-stale MSHR is a secondary miss.
  - It allocates an MSHR copying that mem_tag, issues BUS_NONE, and sets ready=1 if an MSHR is free.
  - On fill, all matching entries are serviced one per cycle in index order.
  - ready=0 and fill-priority block is held until the last matching entry drains.
  - The cache is written once, on the first drain cycle.
- Undefined: every miss issues its own BUS_LOAD; no merging logic.

Test Plan:
- Load addr 0x100 with cachemem_valid=1, data 0xAA, id 3 -> ready=1; next cycle valid=1, data 0xAA, id 3.
- Load miss 0x200, id 5, response=7; 4 cycles later Dmem2Dcache_tag=7, data 0x55 -> wr_en=1 with idx/tag of 0x200; next cycle valid=1, data 0x55, id 5; MSHR freed.
- NUM_MSHR=4: four misses accepted with tags 1..4; fifth miss -> command=BUS_NONE, ready=0 until tag 2 fills, then accepted.
- Miss 0x300 (tag 9), then store 0x300 data 0x1 -> on tag 9 fill, wr_en=0, proc still receives fill data with the original id.
- Fill tag 7 coincides with a load request -> ready=0, no BUS_LOAD issued; the held request is accepted the next cycle.
- MERGE_EN: misses id 1 and id 2 to 0x400 -> one BUS_LOAD; fill -> responses id 1 then id 2 in consecutive cycles, a single wr_en. Without the macro: two BUS_LOADs.
